// File: rtl/flash_arb.sv
// rtl/flash_arb.sv - round-robin arbiter sharing one SPI flash controller among NREQ clients
module flash_arb #(
   parameter int NREQ = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      cli_req,
   input  logic [2*NREQ-1:0]    cli_op,
   input  logic [24*NREQ-1:0]   cli_addr,
   input  logic [8*NREQ-1:0]    cli_wdata,
   output logic [NREQ-1:0]      cli_ack,
   output logic                 cli_err,
   output logic [31:0]          cli_rdata,
   output logic                 cli_busy,
   output logic                 fl_rd_req,
   output logic                 fl_pp_req,
   output logic                 fl_se_req,
   output logic [23:0]          fl_rd_addr,
   output logic [23:0]          fl_wr_addr,
   output logic [23:0]          fl_se_addr,
   output logic [7:0]           fl_wdata,
   input  logic                 fl_ack,
   input  logic [31:0]          fl_rdata
);

   localparam int IW = (NREQ > 2) ? 2 : 1;
   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_PP  = 2'b01;
   localparam logic [1:0] OP_SE  = 2'b10;
   localparam logic [1:0] OP_BAD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    op_q, op_d;
   logic [23:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rd_q, rd_d;
   logic          pp_q, pp_d;
   logic          se_q, se_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         pp_q    <= 1'b0;
         se_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         pp_q    <= pp_d;
         se_q    <= se_d;
      end
   end

   always_comb begin
      logic found;
      int   gi;
      int   j;
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      pp_d    = pp_q;
      se_d    = se_q;
      found   = 1'b0;
      gi      = 0;
      j       = 0;

      // First requester at or after the pointer, wrapping around.
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_q) + k) % NREQ;
         if (!found && cli_req[j]) begin
            found = 1'b1;
            gi    = j;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d   = IW'(gi);
               op_d    = cli_op[2*gi +: 2];
               addr_d  = cli_addr[24*gi +: 24];
               wdata_d = cli_wdata[8*gi +: 8];
               state_d = (cli_op[2*gi +: 2] == OP_BAD) ? S_ERR : S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_d    = (op_q == OP_RD);
            pp_d    = (op_q == OP_PP);
            se_d    = (op_q == OP_SE);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fl_ack) begin
               rd_d = 1'b0;
               pp_d = 1'b0;
               se_d = 1'b0;
               if (op_q == OP_RD) begin
                  rdata_d = fl_rdata;
               end
               state_d = S_DONE;
            end
         end
         S_DONE, S_ERR: begin
            ptr_d   = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + IW'(1);
            state_d = S_GAP;
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cli_ack    = (state_q == S_DONE || state_q == S_ERR) ? (NREQ'(1) << idx_q) : '0;
   assign cli_err    = (state_q == S_ERR);
   assign cli_busy   = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_DONE) || (state_q == S_ERR);
   assign cli_rdata  = rdata_q;
   assign fl_rd_req  = rd_q;
   assign fl_pp_req  = pp_q;
   assign fl_se_req  = se_q;
   assign fl_rd_addr = addr_q;
   assign fl_wr_addr = addr_q;
   assign fl_se_addr = addr_q;
   assign fl_wdata   = wdata_q;

endmodule
